demux1x2_stream_sched: RTL and testbench
========================================

# demux1x2_stream_sched

Packet-aware scheduler that steers one valid/ready input stream onto two output channels and controls when the 1x2 demux path is switched. Destination is taken per packet from the input's destination bit or by alternating round-robin. A packet is locked to one channel until its last beat is accepted. Each output has a one-entry register stage, so the block sits between a packet source and two downstream consumers.

## Interface
- DATA_W, 8, payload width
- CNT_W, 8, width of per-channel delivered-beat counters

- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- mode  input  1  0 = route by in_dest, 1 = alternate channels per packet
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted when in_valid & in_ready
- in_data  input  DATA_W  input payload
- in_dest  input  1  destination channel; used on the first beat of a packet only
- in_last  input  1  marks the final beat of a packet
- out0_valid / out1_valid  output  1  channel beat valid
- out0_ready / out1_ready  input  1  channel consumer ready
- out0_data / out1_data  output  DATA_W  channel payload
- out0_last / out1_last  output  1  channel final-beat flag
- cnt0 / cnt1  output  CNT_W  beats delivered per channel
- busy  output  1  high while a packet is locked (state ≠ IDLE)

## Operation
- States are IDLE, LOCK0 and LOCK1.
- Target channel:
  - In IDLE: `mode ? rr_ptr : in_dest`.
  - In LOCKn: channel n.
- `in_ready = !bufT_valid || outT_ready`, where T is the target channel. This is combinational, with no dependence on in_valid.
- When an input beat is accepted (in_valid & in_ready), its data and last go into the target buffer and that buffer's valid is set.
- When an output handshake occurs (outN_valid & outN_ready) and no new beat is loaded into that buffer, its valid clears.
- A load and a drain of the same buffer in the same cycle keeps valid high, and the buffer takes the new beat.
- State transitions:
  - IDLE, beat accepted with in_last = 0 → LOCKn, where n is the target.
  - IDLE, beat accepted with in_last = 1 (single-beat packet) → stays IDLE.
  - LOCKn, beat accepted with in_last = 1 → IDLE.
  - Otherwise the state holds.
- rr_ptr toggles on every accepted last beat while mode = 1. It holds when mode = 0.
- mode and in_dest are sampled only on a packet's first beat (IDLE acceptance). Changes mid-packet have no effect.
- The non-target channel continues draining its buffer independently; a stalled channel never blocks the other channel's drain.
- Counters:
  - cntN increments on each outN handshake.
  - CNT_W-bit unsigned; wraps from all-ones to 0.
- Reset (asynchronous, any time including mid-packet):
  - State → IDLE.
  - rr_ptr → 0.
  - Both buffer valids → 0, data/last → 0.
  - cnt0/cnt1 → 0.
  - In-flight beats are discarded.
- Reset values of all outputs:
  - out*_valid, out*_data, out*_last, cnt*, busy → 0.
  - in_ready → 1, because both buffers are empty.

## Timing
- Latency: a beat accepted at edge N appears on outT_valid/data/last after edge N, and is held until its handshake.
- Throughput: 1 beat/cycle per packet while the target's out_ready stays high.
- Channel switch between packets costs no bubble. The first beat of a new packet to the other channel can be accepted on the cycle after the previous last beat.
- A held beat's outN_data/outN_last stay stable while outN_valid = 1 and outN_ready = 0.
- busy rises the cycle after acceptance of a non-last first beat, and falls the cycle after acceptance of the last beat.

## Configuration
- DEMUX_SCHED_CNT_EN
  - Defined: cnt0/cnt1 counters present, behaving as above.
  - Undefined: counter registers removed; cnt0/cnt1 tied to 0. All other behaviour is identical.

## Structure
- Shared package demux_sched_pkg holds:
  - the state enum (IDLE, LOCK0, LOCK1);
  - the channel index constants CH0 = 1'b0 and CH1 = 1'b1.
- One sub-module, demux_sched_slot: a one-entry output register with load, drain and valid logic, parameterised by DATA_W. It is instantiated twice.
- FSM, rr_ptr, target selection and counters live in the top block.

## Test plan
- Dest routing: mode = 0, 3-beat packet, in_dest = 1, data 0x11/0x22/0x33, out1_ready = 1 → out1 shows 0x11, 0x22, 0x33 on consecutive cycles; out0_valid stays 0; cnt1 = 3; busy high for 2 cycles.
- Alternation: mode = 1, four single-beat packets 0xA0..0xA3, in_dest held at 0 → channel order 0, 1, 0, 1; cnt0 = 2, cnt1 = 2.
- Backpressure: packet locked to channel 0, out0_ready = 0 after the first beat → in_ready drops after one buffered beat and out0_data stays stable. Raising out0_ready resumes 1 beat/cycle with no loss or duplication.
- Independent drain: out1 holds a beat with out1_ready = 0 while a new packet routes to channel 0 → channel 0 proceeds at full rate and out1 is unaffected.
- Mid-packet reset: assert rst during beat 2 of 4 in LOCK1 → all valids, cnt and busy are 0 immediately, in_ready = 1. After release, the next packet's routing honours in_dest.
- Counter wrap (DEMUX_SCHED_CNT_EN defined, CNT_W = 8): 256 beats to channel 0 → cnt0 returns to 0. With the macro undefined, cnt0 stays 0 throughout.

Source files
------------

// File: rtl/demux_sched_pkg.sv
// Shared types for the 1x2 packet demux scheduler: FSM state encoding and channel ids.
package demux_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

endpackage

// File: rtl/demux1x2_stream_sched_if.sv
// Bundle of the input stream, routing mode and both output channels of the scheduler.
// Every channel uses valid/ready: a beat moves on a cycle where valid & ready are both high,
// the source holds data/last stable while valid is high and ready is low.
interface demux1x2_stream_sched_if #(
    parameter int DATA_W = 8
);
    logic              mode;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_dest;
    logic              in_last;
    logic              out0_valid;
    logic              out0_ready;
    logic [DATA_W-1:0] out0_data;
    logic              out0_last;
    logic              out1_valid;
    logic              out1_ready;
    logic [DATA_W-1:0] out1_data;
    logic              out1_last;

    // master: packet source plus both consumers; slave: the scheduler.
    modport master (
        output mode, in_valid, in_data, in_dest, in_last, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
    );

    modport slave (
        input  mode, in_valid, in_data, in_dest, in_last, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out0_last, out1_valid, out1_data, out1_last
    );
endinterface

// File: rtl/demux_sched_slot.sv
// One-entry output register: a load wins over a drain, so load+drain keeps valid with the new beat.
module demux_sched_slot #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= ld_data;
            last  <= ld_last;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux1x2_stream_sched.sv
// Packet-aware 1x2 stream demux: locks each packet to one channel, routes by in_dest or round-robin.
// Optional per-channel delivered-beat counters are built when DEMUX_SCHED_CNT_EN is defined.
module demux1x2_stream_sched
    import demux_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    demux1x2_stream_sched_if.slave    bus,
    output logic [CNT_W-1:0]          cnt0,
    output logic [CNT_W-1:0]          cnt1,
    output logic                      busy,
    output state_t                    dbg_state
);

    state_t state, state_nxt;
    logic   rr_ptr;
    logic   target;
    logic   accept;
    logic   load0, load1;
    logic   drain0, drain1;

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        if (accept) begin
            case (state)
                IDLE:    if (!bus.in_last) state_nxt = (target == CH1) ? LOCK1 : LOCK0;
                LOCK0,
                LOCK1:   if (bus.in_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // FSM: outputs. mode/in_dest only matter while IDLE, i.e. on a packet's first beat.
    always_comb begin
        target = CH0;
        busy   = 1'b0;
        case (state)
            IDLE:    target = bus.mode ? rr_ptr : bus.in_dest;
            LOCK0:   begin target = CH0; busy = 1'b1; end
            LOCK1:   begin target = CH1; busy = 1'b1; end
            default: target = CH0;
        endcase
    end

    assign dbg_state = state;

    // Ready only looks at the target slot, so a stalled other channel never blocks us.
    assign bus.in_ready = (target == CH1) ? (!bus.out1_valid || bus.out1_ready)
                                          : (!bus.out0_valid || bus.out0_ready);
    assign accept = bus.in_valid && bus.in_ready;
    assign load0  = accept && (target == CH0);
    assign load1  = accept && (target == CH1);
    assign drain0 = bus.out0_valid && bus.out0_ready;
    assign drain1 = bus.out1_valid && bus.out1_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                    rr_ptr <= CH0;
        else if (accept && bus.in_last && bus.mode) rr_ptr <= ~rr_ptr;
    end

    demux_sched_slot #(.DATA_W(DATA_W)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .load    (load0),
        .ld_data (bus.in_data),
        .ld_last (bus.in_last),
        .ready   (bus.out0_ready),
        .valid   (bus.out0_valid),
        .data    (bus.out0_data),
        .last    (bus.out0_last)
    );

    demux_sched_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .load    (load1),
        .ld_data (bus.in_data),
        .ld_last (bus.in_last),
        .ready   (bus.out1_ready),
        .valid   (bus.out1_valid),
        .data    (bus.out1_data),
        .last    (bus.out1_last)
    );

`ifdef DEMUX_SCHED_CNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt1_q;

    // Free-running wrap-around counters of completed output handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (drain0) cnt0_q <= cnt0_q + 1'b1;
            if (drain1) cnt1_q <= cnt1_q + 1'b1;
        end
    end

    assign cnt0 = cnt0_q;
    assign cnt1 = cnt1_q;
`else
    logic unused_drain;
    assign unused_drain = drain0 ^ drain1;
    assign cnt0 = '0;
    assign cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux1x2_stream_sched.sv
// Directed bench for demux1x2_stream_sched; counter expectations follow DEMUX_SCHED_CNT_EN.
module tb_demux1x2_stream_sched;
    import demux_sched_pkg::*;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic             clk;
    logic             rst;
    logic [CNT_W-1:0] cnt0, cnt1;
    logic             busy;
    state_t           dbg_state;

    int tests_run = 0;
    int tests_failed = 0;

    demux1x2_stream_sched_if #(.DATA_W(DATA_W)) bus ();

    demux1x2_stream_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CNT_W-1:0] ec(input int n);
`ifdef DEMUX_SCHED_CNT_EN
        return CNT_W'(n);
`else
        return CNT_W'(n - n);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: present one input beat (or idle) and let combinational outputs settle
    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic dest, input logic last);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_dest  = dest;
        bus.in_last  = last;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.mode = 1'b0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // reset state
        step();
        chk("rst_out0_valid", 32'(bus.out0_valid), 32'd0);
        chk("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("rst_out0_data",  32'(bus.out0_data), 32'd0);
        chk("rst_busy",       32'(busy), 32'd0);
        chk("rst_in_ready",   32'(bus.in_ready), 32'd1);
        chk("rst_cnt0",       32'(cnt0), 32'd0);
        chk("rst_state",      32'(dbg_state), 32'(IDLE));
        step();
        rst = 1'b0;

        // dest routing: 3-beat packet to channel 1
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        drive(1'b1, 8'h11, 1'b1, 1'b0);
        chk("dr_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("dr_b0_data", 32'(bus.out1_data), 32'h11);
        chk("dr_b0_busy", 32'(busy), 32'd1);
        chk("dr_state",   32'(dbg_state), 32'(LOCK1));
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        step();
        chk("dr_b1_data", 32'(bus.out1_data), 32'h22);
        chk("dr_b1_busy", 32'(busy), 32'd1);
        chk("dr_cnt1_1",  32'(cnt1), 32'(ec(1)));
        drive(1'b1, 8'h33, 1'b0, 1'b1);
        step();
        chk("dr_b2_data", 32'(bus.out1_data), 32'h33);
        chk("dr_b2_last", 32'(bus.out1_last), 32'd1);
        chk("dr_b2_busy", 32'(busy), 32'd0);
        chk("dr_out0_valid", 32'(bus.out0_valid), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("dr_out1_empty", 32'(bus.out1_valid), 32'd0);
        chk("dr_cnt1_3",     32'(cnt1), 32'(ec(3)));

        // alternation: single-beat packets, in_dest held at 0
        bus.mode = 1'b1;
        drive(1'b1, 8'hA0, 1'b0, 1'b1);
        step();
        chk("alt_a0_v0", 32'(bus.out0_valid), 32'd1);
        chk("alt_a0_d0", 32'(bus.out0_data), 32'hA0);
        drive(1'b1, 8'hA1, 1'b0, 1'b1);
        step();
        chk("alt_a1_v1", 32'(bus.out1_valid), 32'd1);
        chk("alt_a1_d1", 32'(bus.out1_data), 32'hA1);
        chk("alt_a1_v0", 32'(bus.out0_valid), 32'd0);
        drive(1'b1, 8'hA2, 1'b0, 1'b1);
        step();
        chk("alt_a2_d0", 32'(bus.out0_data), 32'hA2);
        chk("alt_a2_v1", 32'(bus.out1_valid), 32'd0);
        drive(1'b1, 8'hA3, 1'b0, 1'b1);
        step();
        chk("alt_a3_d1", 32'(bus.out1_data), 32'hA3);
        chk("alt_busy",  32'(busy), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("alt_cnt0", 32'(cnt0), 32'(ec(2)));
        chk("alt_cnt1", 32'(cnt1), 32'(ec(5)));

        // backpressure on channel 0
        bus.mode = 1'b0;
        bus.out0_ready = 1'b0;
        drive(1'b1, 8'hB0, 1'b0, 1'b0);
        step();
        chk("bp_b0_data",  32'(bus.out0_data), 32'hB0);
        drive(1'b1, 8'hB1, 1'b1, 1'b0);
        chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        step();
        chk("bp_hold_data",  32'(bus.out0_data), 32'hB0);
        chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_hold_busy",  32'(busy), 32'd1);
        bus.out0_ready = 1'b1;
        #1;
        chk("bp_in_ready_up", 32'(bus.in_ready), 32'd1);
        step();
        chk("bp_b1_data", 32'(bus.out0_data), 32'hB1);
        chk("bp_v1_idle", 32'(bus.out1_valid), 32'd0);
        drive(1'b1, 8'hB2, 1'b1, 1'b1);
        step();
        chk("bp_b2_data", 32'(bus.out0_data), 32'hB2);
        chk("bp_b2_last", 32'(bus.out0_last), 32'd1);
        chk("bp_b2_busy", 32'(busy), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("bp_out0_empty", 32'(bus.out0_valid), 32'd0);
        chk("bp_cnt0", 32'(cnt0), 32'(ec(5)));

        // independent drain: channel 1 stalled while channel 0 streams
        bus.out1_ready = 1'b0;
        drive(1'b1, 8'hC0, 1'b1, 1'b1);
        step();
        chk("ind_c0", 32'(bus.out1_data), 32'hC0);
        drive(1'b1, 8'hD0, 1'b0, 1'b0);
        chk("ind_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        chk("ind_d0",    32'(bus.out0_data), 32'hD0);
        chk("ind_c0_v1", 32'(bus.out1_valid), 32'd1);
        drive(1'b1, 8'hD1, 1'b1, 1'b1);
        step();
        chk("ind_d1",      32'(bus.out0_data), 32'hD1);
        chk("ind_c0_hold", 32'(bus.out1_data), 32'hC0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("ind_out0_empty", 32'(bus.out0_valid), 32'd0);
        chk("ind_out1_held",  32'(bus.out1_valid), 32'd1);
        chk("ind_cnt0",       32'(cnt0), 32'(ec(7)));
        bus.out1_ready = 1'b1;
        step();
        chk("ind_out1_drained", 32'(bus.out1_valid), 32'd0);
        chk("ind_cnt1",         32'(cnt1), 32'(ec(6)));

        // mid-packet reset in LOCK1
        drive(1'b1, 8'hE0, 1'b1, 1'b0);
        step();
        drive(1'b1, 8'hE1, 1'b0, 1'b0);
        step();
        chk("mr_e1_data", 32'(bus.out1_data), 32'hE1);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("mr_out1_valid", 32'(bus.out1_valid), 32'd0);
        chk("mr_busy",       32'(busy), 32'd0);
        chk("mr_cnt0",       32'(cnt0), 32'd0);
        chk("mr_cnt1",       32'(cnt1), 32'd0);
        chk("mr_in_ready",   32'(bus.in_ready), 32'd1);
        step();
        rst = 1'b0;
        drive(1'b1, 8'hF0, 1'b0, 1'b1);
        step();
        chk("mr_f0_v0",   32'(bus.out0_valid), 32'd1);
        chk("mr_f0_d0",   32'(bus.out0_data), 32'hF0);
        chk("mr_f0_v1",   32'(bus.out1_valid), 32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("mr_cnt0_after", 32'(cnt0), 32'(ec(1)));

        // counter wrap: 256 beats to channel 0 from a clean reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, DATA_W'(i), 1'b0, 1'b1);
            step();
        end
        chk("wrap_last_data", 32'(bus.out0_data), 32'hFF);
        chk("wrap_cnt0_255",  32'(cnt0), 32'(ec(255)));
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        chk("wrap_cnt0_0",    32'(cnt0), 32'd0);
        chk("wrap_out0_empty", 32'(bus.out0_valid), 32'd0);
        chk("wrap_cnt1",      32'(cnt1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
